// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle main control FSM feeding ALu_Control
//
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for a 16-bit instruction set and
// drives the datapath enables, the memory request/ready handshake and the
// opsc/Function pair consumed by ALu_Control.
//
// Optional feature macro: CTRL_PERF_CNT_EN (adds cycle_cnt / instr_cnt outputs).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   instr[15:0]         instruction word, captured in FETCH when mem_ready=1
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory completes the current access this cycle
//   mem_req, mem_we     memory request and write strobe
//   iord                memory address select (0=PC, 1=ALU-out)
//   ir_write, pc_write  IR latch and PC update enables
//   pc_src[1:0]         0=ALU, 1=branch target, 2=jump target
//   alu_src_b[1:0]      0=reg B, 1=const 1, 2=sign-extended imm
//   opsc[2:0]           ALU operation class to ALu_Control
//   Function[3:0]       IR function field, zero outside EXEC_R
//   reg_write, reg_dst, mem_to_reg   register file write controls
//   illegal_op          one-cycle pulse on undefined opcode
//   mem_timeout         one-cycle pulse on memory handshake abort
//   cycle_cnt, instr_cnt[31:0]       performance counters (CTRL_PERF_CNT_EN only)

module multicycle_main_control #(
    parameter int OPCODE_W    = 4,
    parameter int FUNC_W      = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        opsc,
    output logic [FUNC_W-1:0] Function,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal_op,
    output logic              mem_timeout
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic [FUNC_W-1:0]   r_func;
    logic [7:0]          r_cnt;
    logic                r_live;
    logic                w_act;
    logic                w_wait;
    logic                w_tmo;
    logic                w_ill;
    logic                w_unused;

    // Only the opcode and function fields of the instruction are ever decoded.
    assign w_unused = ^instr[15-OPCODE_W:FUNC_W];

    // r_live is low for the cycle following reset so that every output reads
    // zero there; outputs are also forced low while reset is asserted so a
    // reset in the middle of an instruction cannot commit a write.
    assign w_act = r_live & ~reset;

    wire w_cnt_done = (r_cnt == 8'(MEM_TIMEOUT));

    always_comb begin
        w_next      = r_state;
        w_wait      = 1'b0;
        w_tmo       = 1'b0;
        w_ill       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_src_b   = 2'd0;
        opsc        = 3'b000;
        Function    = '0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_wait    = 1'b1;
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_cnt_done) begin
                    w_tmo = 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively here.
                alu_src_b = 2'd2;
                case (r_opcode)
                    OPCODE_W'(0): w_next = S_EXEC_R;
                    OPCODE_W'(1): w_next = S_EXEC_I;
                    OPCODE_W'(2),
                    OPCODE_W'(3): w_next = S_MEM_ADDR;
                    OPCODE_W'(4): w_next = S_BRANCH;
                    OPCODE_W'(5): w_next = S_JUMP;
                    default: begin
                        w_ill  = 1'b1;
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                opsc     = 3'b100;
                Function = r_func;
                w_next   = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_b = 2'd2;
                w_next    = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_b = 2'd2;
                w_next    = (r_opcode == OPCODE_W'(3)) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_wait  = 1'b1;
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)       w_next = S_WB_MEM;
                else if (w_cnt_done) w_tmo  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                w_wait  = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready)       w_next = S_FETCH;
                else if (w_cnt_done) w_tmo  = 1'b1;
            end
            S_BRANCH: begin
                opsc     = 3'b011;
                pc_src   = 2'd1;
                pc_write = zero;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        if (w_tmo) w_next = S_FETCH;

        if (!w_act) begin
            w_next     = r_state;
            w_wait     = 1'b0;
            w_tmo      = 1'b0;
            w_ill      = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            alu_src_b  = 2'd0;
            opsc       = 3'b000;
            Function   = '0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
        end

        illegal_op  = w_ill;
        mem_timeout = w_tmo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_live   <= 1'b0;
            r_cnt    <= 8'd0;
            r_opcode <= '0;
            r_func   <= '0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            if (ir_write) begin
                r_opcode <= instr[15:16-OPCODE_W];
                r_func   <= instr[FUNC_W-1:0];
            end
            // Counter restarts on every state change and on an abort, which
            // also covers a timed-out FETCH that stays in FETCH.
            if (w_next != r_state || w_tmo)  r_cnt <= 8'd0;
            else if (w_wait && !mem_ready)   r_cnt <= r_cnt + 8'd1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Retired instruction: normal return to FETCH, excluding illegal/abort exits.
    wire w_retire = w_act && (r_state != S_FETCH) && (w_next == S_FETCH) && !w_ill && !w_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (w_retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - randomized bench with instruction-recipe reference model
module tb_multicycle_main_control;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  opsc;
    logic [3:0]  Function;
    logic        reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_main_control #(.OPCODE_W(4), .FUNC_W(4), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .opsc(opsc),
        .Function(Function), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an instruction is a recipe of steps queued at decode.
    // Empty queue means the controller is fetching.
    localparam int K_DEC = 1, K_EXR = 2, K_WBR = 3, K_EXI = 4, K_WBI = 5, K_ADDR = 6;
    localparam int K_RD = 7, K_WBM = 8, K_WR = 9, K_BR = 10, K_JMP = 11;

    int          m_q[$];
    bit          m_live = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_ir = 16'h0;
    int          m_icnt = 0;

    function automatic logic [20:0] expect_out();
        logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, rw = 0, rd = 0, m2r = 0, ill = 0, tmo = 0;
        logic [1:0] ps = 0, ab = 0;
        logic [2:0] op = 0;
        logic [3:0] fn = 0;
        if (!reset && m_live) begin
            if (m_q.size() == 0) begin
                req = 1; ab = 1;
                if (mem_ready) begin irw = 1; pcw = 1; end
                else if (m_cnt == TMO) tmo = 1;
            end else begin
                case (m_q[0])
                    K_DEC:  begin ab = 2; ill = (m_ir[15:12] > 4'd5); end
                    K_EXR:  begin op = 3'b100; fn = m_ir[3:0]; end
                    K_WBR:  begin rw = 1; rd = 1; end
                    K_EXI:  ab = 2;
                    K_WBI:  rw = 1;
                    K_ADDR: ab = 2;
                    K_RD:   begin req = 1; io = 1; tmo = !mem_ready && m_cnt == TMO; end
                    K_WBM:  begin rw = 1; m2r = 1; end
                    K_WR:   begin req = 1; we = 1; io = 1; tmo = !mem_ready && m_cnt == TMO; end
                    K_BR:   begin op = 3'b011; ps = 1; pcw = zero; end
                    K_JMP:  begin pcw = 1; ps = 2; end
                    default: ;
                endcase
            end
        end
        return {req, we, io, irw, pcw, ps, ab, op, fn, rw, rd, m2r, ill, tmo};
    endfunction

    task automatic model_step();
        int k;
        if (reset) begin
            m_q.delete(); m_live = 0; m_cnt = 0; m_ir = 16'h0; m_icnt = 0;
        end else if (!m_live) begin
            m_live = 1;
        end else if (m_q.size() == 0) begin
            if (mem_ready) begin m_ir = instr; m_q.push_back(K_DEC); m_cnt = 0; end
            else if (m_cnt == TMO) m_cnt = 0;
            else m_cnt++;
        end else begin
            k = m_q[0];
            if (k == K_RD || k == K_WR) begin
                if (mem_ready) begin
                    void'(m_q.pop_front()); m_cnt = 0;
                    if (m_q.size() == 0) m_icnt++;
                end else if (m_cnt == TMO) begin
                    m_q.delete(); m_cnt = 0;
                end else m_cnt++;
            end else begin
                void'(m_q.pop_front()); m_cnt = 0;
                if (k == K_DEC) begin
                    case (m_ir[15:12])
                        4'd0: begin m_q.push_back(K_EXR); m_q.push_back(K_WBR); end
                        4'd1: begin m_q.push_back(K_EXI); m_q.push_back(K_WBI); end
                        4'd2: begin m_q.push_back(K_ADDR); m_q.push_back(K_RD); m_q.push_back(K_WBM); end
                        4'd3: begin m_q.push_back(K_ADDR); m_q.push_back(K_WR); end
                        4'd4: m_q.push_back(K_BR);
                        4'd5: m_q.push_back(K_JMP);
                        default: ;
                    endcase
                end else if (m_q.size() == 0) m_icnt++;
            end
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        logic [20:0] got, exp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            got = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b, opsc,
                   Function, reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout};
            exp = expect_out();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL outputs t=%0t: got %b expected %b", $time, got, exp);
            end
`ifdef CTRL_PERF_CNT_EN
            n_vec++;
            if (instr_cnt !== 32'(m_icnt)) begin
                n_err++;
                $display("FAIL instr_cnt t=%0t: got %0d expected %0d", $time, instr_cnt, m_icnt);
            end
`endif
            model_step();
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic z, input logic [15:0] ins);
        @(posedge clk);
        #1;
        reset = r; mem_ready = rdy; zero = z; instr = ins;
        @(negedge clk);
    endtask

    initial begin
        int req_cnt;
        int mode;
        logic [3:0] op;
        cyc(1, 0, 0, 16'h0);
        cyc(1, 0, 0, 16'h0);
        cyc(0, 1, 0, 16'h0006);
        lit("rst_mem_req", mem_req, 0);
        lit("rst_ir_write", ir_write, 0);
        cyc(0, 1, 0, 16'h0006);
        lit("r_fetch_ir_write", ir_write, 1);
        lit("r_fetch_pc_write", pc_write, 1);
        cyc(0, 0, 0, 16'h0);
        lit("r_decode_alu_src_b", alu_src_b, 2);
        cyc(0, 0, 0, 16'h0);
        lit("r_exec_opsc", opsc, 3'b100);
        lit("r_exec_function", Function, 6);
        cyc(0, 0, 0, 16'h0);
        lit("r_wb_reg_write", reg_write, 1);
        lit("r_wb_reg_dst", reg_dst, 1);
        cyc(0, 0, 0, 16'h0);
        lit("r_back_in_fetch_cycle5", mem_req, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 16'h0);
            lit("tmo_early", mem_timeout, 0);
        end
        cyc(0, 0, 0, 16'h0);
        lit("tmo_pulse", mem_timeout, 1);
        lit("tmo_no_ir_write", ir_write, 0);
        cyc(0, 1, 1, 16'h4000);
        lit("tmo_restart_req", mem_req, 1);
        lit("tmo_restart_pulse", mem_timeout, 0);
        cyc(0, 0, 1, 16'h0);
        cyc(0, 0, 1, 16'h0);
        lit("beq_taken_pc_write", pc_write, 1);
        lit("beq_taken_pc_src", pc_src, 1);
        lit("beq_taken_opsc", opsc, 3'b011);
        cyc(0, 1, 0, 16'h4123);
        cyc(0, 0, 0, 16'h0);
        cyc(0, 0, 0, 16'h0);
        lit("beq_not_taken_pc_write", pc_write, 0);
        lit("beq_not_taken_opsc", opsc, 3'b011);
        cyc(0, 1, 0, 16'hF000);
        cyc(0, 0, 0, 16'h0);
        lit("illegal_pulse", illegal_op, 1);
        cyc(0, 1, 0, 16'h3000);
        lit("illegal_back_fetch", mem_req, 1);
        lit("illegal_no_reg_write", reg_write, 0);
        cyc(0, 0, 0, 16'h0);
        cyc(0, 0, 0, 16'h0);
        cyc(0, 0, 0, 16'h0);
        lit("sw_mem_we", mem_we, 1);
        cyc(1, 0, 0, 16'h0);
        lit("sw_reset_gates_req", mem_req, 0);
        cyc(0, 1, 0, 16'h2000);
        lit("post_reset_mem_req", mem_req, 0);
        lit("post_reset_mem_we", mem_we, 0);
`ifdef CTRL_PERF_CNT_EN
        lit("post_reset_instr_cnt", instr_cnt, 0);
`endif
        cyc(0, 1, 0, 16'h2000);
        lit("lw_fetch", ir_write, 1);
        cyc(0, 0, 0, 16'h0);
        cyc(0, 0, 0, 16'h0);
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, (i == 3), 0, 16'h0);
            if (mem_req) req_cnt++;
        end
        lit("lw_mem_req_cycles", req_cnt, 4);
        cyc(0, 0, 0, 16'h0);
        lit("lw_wb_mem_to_reg", mem_to_reg, 1);
        lit("lw_wb_reg_write", reg_write, 1);
        cyc(0, 0, 0, 16'h0);
        lit("lw_cpi8_back_in_fetch", {mem_req, iord}, 2'b10);

        mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) mode = $urandom_range(0, 2);
            op = ($urandom_range(0, 7) < 7) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
            cyc(($urandom_range(0, 199) == 0),
                (mode == 0) ? ($urandom_range(0, 3) != 0) :
                (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0,
                1'($urandom_range(0, 1)),
                {op, 12'($urandom)});
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
